// File: rtl/branch_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_ctrl_if
// Purpose : Bundles the ID-stage branch request, the operand/forwarding status
//           and the PC-redirect / statistics outputs of branch_ctrl.
// Signals :
//   br_valid      branch-class instruction present in ID this cycle
//   br_type       00 cond, 01 PC-relative, 10 register jump, 11 not-a-branch
//   br_kind       conditional sense: 0 taken on zero, 1 taken on non-zero
//   operand       tested register value, also the register-jump target
//   operand_ready operand valid this cycle
//   pc_plus1      address of the instruction after the branch
//   offset        sign-extended branch offset
//   stall_id      hold IF/ID while waiting for the operand (combinational)
//   pc_sel        PC loads pc_target on the next edge
//   pc_target     redirect address
//   flush_if      squash the instruction in IF/ID
//   br_done       one-cycle resolution pulse
//   br_cnt        resolved-branch counter
//   taken_cnt     taken-branch counter
// Modports: master = pipeline side, slave = branch_ctrl.
// -----------------------------------------------------------------------------
interface branch_ctrl_if;
  logic        br_valid;
  logic [1:0]  br_type;
  logic        br_kind;
  logic [15:0] operand;
  logic        operand_ready;
  logic [15:0] pc_plus1;
  logic [15:0] offset;
  logic        stall_id;
  logic        pc_sel;
  logic [15:0] pc_target;
  logic        flush_if;
  logic        br_done;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  modport master (
    output br_valid, br_type, br_kind, operand, operand_ready, pc_plus1, offset,
    input  stall_id, pc_sel, pc_target, flush_if, br_done, br_cnt, taken_cnt
  );

  modport slave (
    input  br_valid, br_type, br_kind, operand, operand_ready, pc_plus1, offset,
    output stall_id, pc_sel, pc_target, flush_if, br_done, br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
// Purpose : Resolves ID-stage branches. Waits for the tested operand when it
//           is not yet available, then issues a one-cycle PC redirect and
//           IF/ID flush for taken branches, and keeps resolved/taken counts.
// Ports   :
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   br_if  branch_ctrl_if.slave bundle (request in, redirect/stats out)
// -----------------------------------------------------------------------------
module branch_ctrl (
  input  logic          clk,
  input  logic          rst,
  branch_ctrl_if.slave  br_if
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_REDIR = 2'b10;

  // Taken decision; type 11 is not a branch and never redirects.
  function automatic logic calc_taken(input logic [1:0] typ, input logic kind,
                                      input logic [15:0] opnd);
    logic res;
    case (typ)
      2'b00:   res = (opnd == 16'h0000) ^ kind;
      2'b01:   res = 1'b1;
      2'b10:   res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Redirect address; the PC-relative sum wraps modulo 2^16.
  function automatic logic [15:0] calc_target(input logic [1:0] typ,
                                              input logic [15:0] opnd,
                                              input logic [15:0] pc1,
                                              input logic [15:0] off);
    logic [15:0] res;
    if (typ == 2'b10) begin
      res = opnd;
    end else begin
      res = pc1 + off;
    end
    return res;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [1:0]  type_q, type_d;
  logic        kind_q, kind_d;
  logic [15:0] pc1_q, pc1_d;
  logic [15:0] off_q, off_d;
  logic        pc_sel_q, pc_sel_d;
  logic        flush_q, flush_d;
  logic        done_q, done_d;
  logic [15:0] target_q, target_d;
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic [1:0]  ev_type_s;
  logic        ev_kind_s;
  logic [15:0] ev_pc1_s;
  logic [15:0] ev_off_s;
  logic        accept_s;
  logic        pending_s;
  logic        resolve_s;
  logic        taken_s;
  logic [15:0] target_s;

  // Branch fields under evaluation: live in IDLE, latched copy while waiting.
  always_comb begin
    ev_type_s = type_q;
    ev_kind_s = kind_q;
    ev_pc1_s  = pc1_q;
    ev_off_s  = off_q;
    if (state_q == ST_IDLE) begin
      ev_type_s = br_if.br_type;
      ev_kind_s = br_if.br_kind;
      ev_pc1_s  = br_if.pc_plus1;
      ev_off_s  = br_if.offset;
    end else begin
      ev_type_s = type_q;
      ev_kind_s = kind_q;
      ev_pc1_s  = pc1_q;
      ev_off_s  = off_q;
    end
  end

  // A branch is pending when newly accepted or still waiting for its operand.
  assign accept_s  = (state_q == ST_IDLE) && br_if.br_valid;
  assign pending_s = accept_s || (state_q == ST_WAIT);
  assign resolve_s = pending_s && br_if.operand_ready;
  assign taken_s   = calc_taken(ev_type_s, ev_kind_s, br_if.operand);
  assign target_s  = calc_target(ev_type_s, br_if.operand, ev_pc1_s, ev_off_s);

  // Stall is the only combinational output; reset forces it low.
  assign br_if.stall_id = !rst && pending_s && !br_if.operand_ready;

  // Next-state, field latching, registered outputs and counters.
  always_comb begin
    state_d     = ST_IDLE;
    type_d      = type_q;
    kind_d      = kind_q;
    pc1_d       = pc1_q;
    off_d       = off_q;
    pc_sel_d    = resolve_s && taken_s;
    flush_d     = resolve_s && taken_s;
    done_d      = resolve_s;
    target_d    = target_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (br_if.br_valid && !br_if.operand_ready) begin
          state_d = ST_WAIT;
        end else if (resolve_s && taken_s) begin
          state_d = ST_REDIR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!br_if.operand_ready) begin
          state_d = ST_WAIT;
        end else if (taken_s) begin
          state_d = ST_REDIR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept_s) begin
      type_d = br_if.br_type;
      kind_d = br_if.br_kind;
      pc1_d  = br_if.pc_plus1;
      off_d  = br_if.offset;
    end else begin
      type_d = type_q;
      kind_d = kind_q;
      pc1_d  = pc1_q;
      off_d  = off_q;
    end

    if (resolve_s) begin
      br_cnt_d = br_cnt_q + 16'd1;
      if (taken_s) begin
        taken_cnt_d = taken_cnt_q + 16'd1;
        target_d    = target_s;
      end else begin
        taken_cnt_d = taken_cnt_q;
        target_d    = target_q;
      end
    end else begin
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      type_q      <= 2'b00;
      kind_q      <= 1'b0;
      pc1_q       <= 16'h0000;
      off_q       <= 16'h0000;
      pc_sel_q    <= 1'b0;
      flush_q     <= 1'b0;
      done_q      <= 1'b0;
      target_q    <= 16'h0000;
      br_cnt_q    <= 16'h0000;
      taken_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      kind_q      <= kind_d;
      pc1_q       <= pc1_d;
      off_q       <= off_d;
      pc_sel_q    <= pc_sel_d;
      flush_q     <= flush_d;
      done_q      <= done_d;
      target_q    <= target_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_if.pc_sel    = pc_sel_q;
  assign br_if.flush_if  = flush_q;
  assign br_if.br_done   = done_q;
  assign br_if.pc_target = target_q;
  assign br_if.br_cnt    = br_cnt_q;
  assign br_if.taken_cnt = taken_cnt_q;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001: clk  in  1  single system clock; all state updates on rising edge.
REQ-002: rst  in  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-003: br_valid  in  1  branch-class instruction present in ID stage this cycle.
REQ-004: br_type  in  2  00=conditional (BEQZ/BNEZ), 01=unconditional PC-relative (B), 10=register jump (JR), 11=reserved (treated as not-a-branch).
REQ-005: br_kind  in  1  conditional sense: 0=taken when operand==0 (BEQZ), 1=taken when operand!=0 (BNEZ).
REQ-006: operand  in  16  tested register value; also the JR target.
REQ-007: operand_ready  in  1  operand valid this cycle (from forwarding/hazard logic).
REQ-008: pc_plus1  in  16  address of instruction following the branch.
REQ-009: offset  in  16  sign-extended branch offset.
REQ-010: stall_id  out  1  hold IF/ID; branch waiting for operand.
REQ-011: pc_sel  out  1  1 = PC loads pc_target next edge.
REQ-012: pc_target  out  16  redirect address.
REQ-013: flush_if  out  1  squash the instruction currently in IF/ID.
REQ-014: br_done  out  1  one-cycle pulse, branch resolved.
REQ-015: br_cnt  out  16  resolved-branch counter.
REQ-016: taken_cnt  out  16  taken-branch counter.

Function
REQ-017: States IDLE, WAIT, REDIR; 2-bit encoding; unused encodings SHALL go to IDLE next cycle.
REQ-018: taken SHALL be computed as ((operand==16'h0000) XOR br_kind) for type 00, 1 for types 01/10, 0 for type 11.
REQ-019: Target SHALL be pc_plus1+offset (16-bit, modulo 2^16, carry discarded) for types 00/01, operand for type 10.
REQ-020: On acceptance (IDLE and br_valid), br_type, br_kind, pc_plus1, offset SHALL be latched; WAIT evaluates using latched fields and live operand.
REQ-021: IDLE, br_valid, operand_ready, taken -> REDIR; pc_target registered; br_done=1 next cycle.
REQ-022: IDLE, br_valid, operand_ready, not taken -> IDLE; br_done=1 next cycle; pc_sel, flush_if stay 0.
REQ-023: IDLE, br_valid, !operand_ready -> WAIT; stall_id SHALL assert combinationally in the same cycle and every WAIT cycle until resolution.
REQ-024: WAIT, operand_ready -> REDIR (taken) or IDLE (not taken); stall_id deasserted that cycle; br_done=1 next cycle.
REQ-025: WAIT has no timeout; br_valid ignored while in WAIT.
REQ-026: REDIR lasts exactly one cycle: pc_sel=1, flush_if=1, pc_target valid; -> IDLE; br_valid ignored in REDIR (that instruction is flushed).
REQ-027: Resolution latency: 1 cycle after operand_ready; redirect visible exactly 1 cycle after the resolving edge.
REQ-028: br_cnt increments by 1 per br_done pulse; taken_cnt increments when that branch was taken; both wrap FFFF->0000.
REQ-029: Type 11 accepted in IDLE SHALL resolve not-taken and increment br_cnt only.
REQ-030: pc_sel, flush_if, br_done SHALL be registered outputs; stall_id is the only combinational output.

Reset
REQ-031: With rst=1 at an edge: state=IDLE, stall_id=0 (whenever rst=1), pc_sel=0, flush_if=0, br_done=0, pc_target=0000, br_cnt=0000, taken_cnt=0000, latched fields 0.
REQ-032: rst asserted in WAIT or REDIR SHALL abort the branch with no redirect, no br_done, no counter update.
REQ-033: rst SHALL dominate every other input in the same cycle.

Verification
REQ-034: BEQZ, operand=0000, ready, pc_plus1=0010, offset=FFFE -> next cycle pc_sel=1, flush_if=1, pc_target=000E, br_done=1; taken_cnt=1, br_cnt=1.
REQ-035: BNEZ, operand=0000, ready -> br_done=1, pc_sel=0, flush_if=0; br_cnt+1, taken_cnt unchanged.
REQ-036: JR, operand_ready low 3 cycles then high with operand=1234 -> stall_id=1 for 3 cycles, then pc_target=1234, pc_sel=1 one cycle.
REQ-037: B, pc_plus1=FFFF, offset=0002 -> pc_target=0001 (wrap).
REQ-038: rst=1 during WAIT -> next cycle IDLE, stall_id=0, no pc_sel, counters 0000.
REQ-039: Preload br_cnt=FFFF via 65535 branches, one more -> br_cnt=0000.
